rand_delay_fifo: RTL and testbench

Scenario-side elastic channel that re-times a valid/ready stream with a per-word programmable latency. It is the receiving counterpart to the plain shift-register delay line: instead of shifting every cycle, it accepts words under handshake, holds each for a latency sampled at acceptance, and releases them in order under downstream back-pressure. Bench models sit between the accelerator's memory/bus ports and behavioural slaves, so that the returned-data timing is variable.

---
 rtl/rand_delay_pkg.sv | 35 +++
 rtl/rand_delay_entry.sv | 61 ++++++
 rtl/rand_delay_fifo.sv | 125 ++++++++++++
 tb/tb_rand_delay_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_delay_pkg.sv
// -----------------------------------------------------------------------------
// rand_delay_pkg
// Shared definitions for the random-delay FIFO and the bench models that sit
// next to it.
//   DELAY_W        - width of the per-word latency field and entry counters
//   DEFAULT_DEPTH  - default entry count
//   PTR_MAX_W      - container width for pointer comparison (covers depth 64)
//   ptr_full()     - wrap-flag pointer full test (low bits equal, MSB differs)
//   ptr_empty()    - pointer empty test (all bits equal)
// -----------------------------------------------------------------------------
package rand_delay_pkg;

    localparam int DELAY_W       = 8;
    localparam int DEFAULT_DEPTH = 8;
    localparam int PTR_MAX_W     = 8;

    typedef logic [PTR_MAX_W-1:0] ptr_ext_t;

    // Pointers are zero-extended into ptr_ext_t by the caller; aw is the
    // number of address bits, so bit aw is the wrap flag.
    function automatic logic ptr_full(ptr_ext_t wp, ptr_ext_t rp, int aw);
        ptr_ext_t diff;
        ptr_ext_t low_mask;
        ptr_ext_t msb_mask;
        diff     = wp ^ rp;
        low_mask = ~(ptr_ext_t'('1) << aw);
        msb_mask = ptr_ext_t'(1) << aw;
        return ((diff & low_mask) == '0) && ((diff & msb_mask) != '0);
    endfunction

    function automatic logic ptr_empty(ptr_ext_t wp, ptr_ext_t rp);
        return wp == rp;
    endfunction

endpackage

// File: rtl/rand_delay_entry.sv
// -----------------------------------------------------------------------------
// rand_delay_entry
// Latency counter for one FIFO slot. Loaded with the sampled delay when the
// slot is written; counts down on enabled cycles and reports expiry.
//   clk_core   in   core clock
//   rst_x      in   asynchronous active-low reset
//   i_load     in   slot is written this cycle (takes priority over countdown)
//   i_delay    in   latency to load
//   i_en       in   countdown enable
//   o_expired  out  slot may be released
//
// A freshly loaded slot carries a pending flag that costs one extra enabled
// cycle after the counter reaches zero, which gives a total latency of
// 1 + delay enabled cycles from the push edge to o_valid.
// -----------------------------------------------------------------------------
module rand_delay_entry
    import rand_delay_pkg::*;
(
    input  logic               clk_core,
    input  logic               rst_x,
    input  logic               i_load,
    input  logic [DELAY_W-1:0] i_delay,
    input  logic               i_en,
    output logic               o_expired
);

    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic               pend_q, pend_d;

    // NOTE: every variable assigned here gets its hold value first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (i_load) begin
            cnt_d  = i_delay;
            pend_d = 1'b1;
        end else if (i_en) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - DELAY_W'(1);
            end else begin
                pend_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_core or negedge rst_x) begin
        if (!rst_x) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign o_expired = (cnt_q == '0) && !pend_q;

endmodule

// File: rtl/rand_delay_fifo.sv
// -----------------------------------------------------------------------------
// rand_delay_fifo
// Elastic valid/ready channel that holds each accepted word for a latency
// sampled at acceptance and releases words strictly in order.
//   clk_core  in   core clock, rising edge
//   rst_x     in   asynchronous active-low reset
//   i_en      in   countdown enable (handshakes stay live when 0)
//   i_delay   in   latency for the word accepted this cycle
//   i_valid   in   upstream word valid
//   o_ready   out  upstream may push (registered-derived)
//   i_data    in   upstream word
//   o_valid   out  head word has expired and is presented
//   i_ready   in   downstream accepts
//   o_data    out  head word
//   o_level   out  occupied entries
// -----------------------------------------------------------------------------
module rand_delay_fifo
    import rand_delay_pkg::*;
#(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = DEFAULT_DEPTH,
    parameter int P_AW    = $clog2(P_DEPTH)
)
(
    input  logic               clk_core,
    input  logic               rst_x,
    input  logic               i_en,
    input  logic [DELAY_W-1:0] i_delay,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [P_WIDTH-1:0] i_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [P_WIDTH-1:0] o_data,
    output logic [P_AW:0]      o_level
);

    typedef logic [P_AW:0] ptr_t;

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    ptr_t level_q, level_d;

    logic [P_WIDTH-1:0] mem_q [P_DEPTH];

    logic [P_DEPTH-1:0] load_vec;
    logic [P_DEPTH-1:0] expired_vec;
    logic [P_AW-1:0]    waddr;
    logic [P_AW-1:0]    raddr;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign waddr = wptr_q[P_AW-1:0];
    assign raddr = rptr_q[P_AW-1:0];

    // Full/empty come only from registered pointers, so o_ready has no
    // combinational path from i_ready: a pop at full frees a slot for the
    // following cycle, not this one.
    assign full  = ptr_full(ptr_ext_t'(wptr_q), ptr_ext_t'(rptr_q), P_AW);
    assign empty = ptr_empty(ptr_ext_t'(wptr_q), ptr_ext_t'(rptr_q));

    assign o_ready = !full;
    // Only the head is examined, so an expired younger word waits behind
    // an older one that is still counting.
    assign o_valid = !empty && expired_vec[raddr];
    assign o_data  = mem_q[raddr];
    assign o_level = level_q;

    assign push = i_valid && o_ready;
    assign pop  = o_valid && i_ready;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) begin
            wptr_d = wptr_q + ptr_t'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + ptr_t'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + ptr_t'(1);
            2'b01:   level_d = level_q - ptr_t'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_core or negedge rst_x) begin
        if (!rst_x) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // NOTE: the data array has no reset; stale contents are unreachable
    // because o_valid is gated by the reset pointers, and leaving it out
    // keeps the array mappable to plain RAM.
    always_ff @(posedge clk_core) begin
        if (push) begin
            mem_q[waddr] <= i_data;
        end
    end

    for (genvar gi = 0; gi < P_DEPTH; gi++) begin : g_entry
        assign load_vec[gi] = push && (waddr == P_AW'(gi));

        rand_delay_entry u_entry (
            .clk_core  (clk_core),
            .rst_x     (rst_x),
            .i_load    (load_vec[gi]),
            .i_delay   (i_delay),
            .i_en      (i_en),
            .o_expired (expired_vec[gi])
        );
    end

endmodule

// File: tb/tb_rand_delay_fifo.sv
// -----------------------------------------------------------------------------
// tb_rand_delay_fifo
// Directed bench for rand_delay_fifo (P_WIDTH=8, P_DEPTH=8). Inputs change on
// the falling edge; outputs are sampled on the falling edge before inputs move.
// Timeline comments use t for the rising edge that accepts the first word.
// -----------------------------------------------------------------------------
module tb_rand_delay_fifo;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AW = 3;

    logic          clk_core = 1'b0;
    logic          rst_x;
    logic          i_en;
    logic [7:0]    i_delay;
    logic          i_valid;
    logic          o_ready;
    logic [W-1:0]  i_data;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_data;
    logic [AW:0]   o_level;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_core = ~clk_core;

    rand_delay_fifo #(
        .P_WIDTH (W),
        .P_DEPTH (D),
        .P_AW    (AW)
    ) dut (
        .clk_core (clk_core),
        .rst_x    (rst_x),
        .i_en     (i_en),
        .i_delay  (i_delay),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_level  (o_level)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        @(negedge clk_core);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_x   = 1'b0;
        i_en    = 1'b1;
        i_delay = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;

        // ---- reset held for 3 cycles ----
        repeat (3) @(posedge clk_core);
        @(negedge clk_core);
        rst_x = 1'b1;
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 1);
        check("rst_level", o_level, 0);

        // ---- single word, delay 4: visible after t+5, popped at t+6 ----
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'hA5;
        i_delay = 8'd4;
        tick();                          // t
        i_valid = 1'b0;
        i_delay = 8'hFF;                 // not sampled without a push
        check("one_level_after_push", o_level, 1);
        check("one_valid_t0", o_valid, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("one_valid_t%0d", k), o_valid, 0);
        end
        tick();                          // t+5
        check("one_valid_t5", o_valid, 1);
        check("one_data", o_data, 8'hA5);
        check("one_level_held", o_level, 1);
        tick();                          // t+6 pop
        check("one_level_popped", o_level, 0);
        check("one_valid_popped", o_valid, 0);

        // ---- ordering: delays 6,0,2 released together at word 1 expiry ----
        i_valid = 1'b1;
        i_data  = 8'd1; i_delay = 8'd6; tick();   // t
        i_data  = 8'd2; i_delay = 8'd0; tick();   // t+1
        i_data  = 8'd3; i_delay = 8'd2; tick();   // t+2
        i_valid = 1'b0;
        i_delay = 8'd0;
        check("ord_blocked_valid", o_valid, 0);
        check("ord_level3", o_level, 3);
        ticks(4);                                 // t+6
        check("ord_valid_t6", o_valid, 0);
        tick();                                   // t+7
        check("ord_valid_w1", o_valid, 1);
        check("ord_data_w1", o_data, 1);
        check("ord_level_w1", o_level, 3);
        tick();
        check("ord_valid_w2", o_valid, 1);
        check("ord_data_w2", o_data, 2);
        check("ord_level_w2", o_level, 2);
        tick();
        check("ord_valid_w3", o_valid, 1);
        check("ord_data_w3", o_data, 3);
        check("ord_level_w3", o_level, 1);
        tick();
        check("ord_valid_end", o_valid, 0);
        check("ord_level_end", o_level, 0);

        // ---- full and back-pressure: 10 offered, 8 accepted ----
        i_ready = 1'b0;
        i_delay = 8'd0;
        for (int n = 0; n < 8; n++) begin
            check($sformatf("full_ready_before_%0d", n), o_ready, 1);
            i_valid = 1'b1;
            i_data  = W'(16 + n);
            tick();
        end
        check("full_ready_low", o_ready, 0);
        check("full_level8", o_level, 8);
        i_data = 8'h18;
        ticks(2);                                 // two words held upstream
        check("full_ready_still_low", o_ready, 0);
        check("full_level_still8", o_level, 8);
        check("full_head_valid", o_valid, 1);
        check("full_head_data", o_data, 8'h10);
        i_ready = 1'b1;
        tick();                                   // pop only
        check("drain_level_first_pop", o_level, 7);
        check("drain_ready_back", o_ready, 1);
        check("drain_data_first", o_data, 8'h11);
        tick();                                   // push 0x18 + pop
        check("drain_level_pushpop", o_level, 7);
        check("drain_data_second", o_data, 8'h12);
        i_data = 8'h19;
        tick();                                   // push 0x19 + pop
        check("drain_level_pushpop2", o_level, 7);
        i_valid = 1'b0;
        for (int n = 0; n < 7; n++) begin
            check($sformatf("drain_valid_%0d", n), o_valid, 1);
            check($sformatf("drain_data_%0d", n), o_data, 32'(8'h13 + n));
            tick();
        end
        check("drain_level_end", o_level, 0);
        check("drain_valid_end", o_valid, 0);

        // ---- freeze: delay 3, i_en low for 5 cycles, release 5 late ----
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'h5C;
        i_delay = 8'd3;
        tick();                                   // t
        i_valid = 1'b0;
        tick();                                   // t+1
        i_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();                               // t+2 .. t+6
            check($sformatf("frz_valid_frozen_%0d", k), o_valid, 0);
        end
        i_en = 1'b1;
        ticks(2);                                 // t+8
        check("frz_valid_t8", o_valid, 0);
        tick();                                   // t+9
        check("frz_valid_t9", o_valid, 1);
        check("frz_data", o_data, 8'h5C);
        for (int k = 0; k < 3; k++) begin
            i_delay = 8'(k * 7);
            tick();
            check($sformatf("frz_hold_valid_%0d", k), o_valid, 1);
            check($sformatf("frz_hold_data_%0d", k), o_data, 8'h5C);
        end
        i_ready = 1'b1;
        tick();
        check("frz_level_end", o_level, 0);

        // ---- throughput: delay 0 stream, one word per cycle ----
        i_delay = 8'd0;
        for (int k = 0; k < 6; k++) begin
            i_valid = 1'b1;
            i_data  = W'(8'h30 + k);
            tick();
            check($sformatf("thr_level_%0d", k), o_level, (k == 0) ? 1 : 2);
            if (k > 0) begin
                check($sformatf("thr_valid_%0d", k), o_valid, 1);
                check($sformatf("thr_data_%0d", k), o_data, 32'(8'h30 + k - 1));
            end
        end
        i_valid = 1'b0;
        tick();
        check("thr_level_tail", o_level, 1);
        check("thr_data_tail", o_data, 8'h35);
        tick();
        check("thr_level_end", o_level, 0);

        // ---- asynchronous reset between edges ----
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'h77; i_delay = 8'd0; tick();
        i_data  = 8'h78; i_delay = 8'd9; tick();
        i_valid = 1'b0;
        check("arst_pre_valid", o_valid, 1);
        check("arst_pre_level", o_level, 2);
        #2;
        rst_x = 1'b0;
        #1;
        check("arst_valid", o_valid, 0);
        check("arst_level", o_level, 0);
        check("arst_ready", o_ready, 1);
        @(negedge clk_core);
        rst_x = 1'b1;
        check("arst_release_level", o_level, 0);
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h99;
        i_delay = 8'd1;
        tick();                                   // t
        i_valid = 1'b0;
        check("post_rst_valid_t0", o_valid, 0);
        tick();                                   // t+1
        check("post_rst_valid_t1", o_valid, 0);
        tick();                                   // t+2
        check("post_rst_valid_t2", o_valid, 1);
        check("post_rst_data", o_data, 8'h99);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
